usb3_tp_arbiter: RTL and testbench
==================================

// Module: usb3_tp_arbiter
// PURPOSE
//  Shares the single link-layer transaction-packet (TP) transmit slot between the three protocol-layer
//  TP requesters A/B/C (ACK-to-DPH, STATUS-ACK, NRDY/ERDY). It latches the winning request's fields and
//  drives the link until the link acknowledges. It then returns a one-cycle ack to the winner, with
//  fixed-priority or round-robin arbitration, a send timeout and sticky error flags.
// PARAMETERS
//  RR        0     0: fixed priority A>B>C; 1: round-robin starting after last acked winner
//  HOLDOFF   1     cycles (>=1) spent in HOLD after ack/timeout before re-arbitrating
//  TIMEOUT   1023  max cycles in SEND awaiting link_tp_ack (11-bit counter, value 1..2047)
// PORTS
//  local_clk      in   1   sole clock
//  reset          in   1   synchronous, active-high reset
//  req_a/b/c      in   1   request; held high until (and possibly 1 cycle past) its ack
//  req_a/b/c_tp   in   36  fields {retry[35],dir[34],subtype[33:30],endp[29:26],nump[25:21],seq[20:16],stream[15:0]}
//  ack_a/b/c      out  1   single-cycle pulse: this requester's TP was accepted by link
//  link_tp        out  1   TP transmit request to link layer
//  link_tp_fields out  36  latched fields of current winner (same packing)
//  link_tp_ack    in   1   single-cycle pulse from link: TP taken
//  grant          out  3   one-hot winner {c,b,a}, valid while in SEND, else 0
//  err_timeout    out  1   sticky: SEND expired without link_tp_ack
//  err_spurious   out  1   sticky: link_tp_ack seen outside SEND
// BEHAVIOUR
//  Reset: all outputs 0, state ARB, RR pointer = C (so A is first), hold/timeout counters 0. Reset wins
//   over every other event, including mid-SEND; no ack pulse is issued for an aborted TP.
//  FSM ARB -> SEND -> HOLD -> ARB; all outputs registered.
//  ARB: if any req high, select winner (RR=0: A>B>C; RR=1: first high req after pointer, wrapping C->A);
//   link_tp<=1, link_tp_fields<=winner fields, grant<=onehot, tmo_cnt<=0, ->SEND. Nothing high: stay.
//   Latency: req sampled in cycle N -> link_tp=1 in N+1.
//  SEND: link_tp and fields held constant, insensitive to requester changes (a winner that drops req
//   still completes and still receives its ack). tmo_cnt increments each cycle.
//   link_tp_ack in cycle M: link_tp<=0, grant<=0, ack_<winner><=1 (high only in M+1), RR pointer<=winner,
//   hold_cnt<=HOLDOFF-1, ->HOLD.
//   tmo_cnt==TIMEOUT-1 with no ack: link_tp<=0, grant<=0, err_timeout<=1, no ack pulse, pointer
//   unchanged, ->HOLD; winner re-competes normally. Ack in the same cycle as expiry counts as ack.
//  HOLD: all requests ignored (absorbs the stale req a registered requester shows the cycle after its ack);
//   decrement hold_cnt, ->ARB when 0. HOLDOFF=1 -> exactly one HOLD cycle, ARB in M+2.
//  link_tp_ack in ARB or HOLD: err_spurious<=1, otherwise ignored.
//  Error flags clear only on reset. At most one ack_x high per cycle; never two TPs outstanding.
// TESTING
//  1 req_a, fields retry=0 dir=0 sub=4'h1 endp=2 nump=1 seq=5 stream=0 in N; link_tp_ack N+3 -> link_tp=1
//    N+1..N+3 with exact fields, grant=3'b001, ack_a=1 only N+4, link_tp=0 N+4.
//  2 req_a,b,c held, link acks 2 cycles after each link_tp -> RR=0 and RR=1 order A,B,C. Then A
//    re-requests after its ack, B,C held -> RR=0 grants A,A,A; RR=1 grants B,C,A.
//  3 requester keeps req high 1 cycle past ack, then drops -> exactly one link_tp burst, no second grant.
//  4 TIMEOUT=8, req_b held, no link ack -> link_tp high 8 cycles then 0, err_timeout=1, no ack_b;
//    B re-granted after HOLD; later ack gives ack_b pulse, err_timeout remains 1.
//  5 reset pulsed during SEND -> next cycle link_tp=0, grant=0, all acks 0, errors 0, state ARB.
//  6 link_tp_ack with no request pending -> err_spurious=1, no ack pulse. req_c dropped mid-SEND ->
//    fields unchanged, ack_c still pulsed on link ack.

Source files
------------

// File: rtl/usb3_tp_arbiter.sv
// usb3_tp_arbiter: shares the single link-layer TP transmit slot between the
// three protocol-layer TP requesters (A: ACK-to-DPH, B: STATUS-ACK, C: NRDY/ERDY).
// The winner's fields are latched and presented to the link until it
// acknowledges or the send timer expires. A short hold-off then absorbs the
// stale request of a registered requester before the next arbitration round.
module usb3_tp_arbiter #(
  parameter bit RR      = 1'b0,
  parameter int HOLDOFF = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        req_c,
  input  logic [35:0] req_a_tp,
  input  logic [35:0] req_b_tp,
  input  logic [35:0] req_c_tp,
  output logic        ack_a,
  output logic        ack_b,
  output logic        ack_c,
  output logic        link_tp,
  output logic [35:0] link_tp_fields,
  input  logic        link_tp_ack,
  output logic [2:0]  grant,
  output logic        err_timeout,
  output logic        err_spurious
);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_SEND,
    ST_HOLD
  } state_t;

  localparam logic [10:0] TMO_LAST  = 11'(TIMEOUT - 1);
  localparam logic [10:0] HOLD_INIT = 11'(HOLDOFF - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  owner;
  logic [10:0] tmo_cnt;
  logic [10:0] hold_cnt;
  logic        win_valid;
  logic [1:0]  win_idx;

  // Pick the winner among live requests: fixed A>B>C, or round-robin
  // starting with the requester after the last acknowledged winner.
  always_comb begin
    win_valid = req_a | req_b | req_c;
    win_idx   = 2'd0;
    if (!RR || rr_ptr == 2'd2) begin
      if (req_a)      win_idx = 2'd0;
      else if (req_b) win_idx = 2'd1;
      else if (req_c) win_idx = 2'd2;
    end else if (rr_ptr == 2'd0) begin
      if (req_b)      win_idx = 2'd1;
      else if (req_c) win_idx = 2'd2;
      else if (req_a) win_idx = 2'd0;
    end else begin
      if (req_c)      win_idx = 2'd2;
      else if (req_a) win_idx = 2'd0;
      else if (req_b) win_idx = 2'd1;
    end
  end

  // Arbitration FSM with all outputs registered; reset aborts any TP in flight.
  always_ff @(posedge local_clk) begin
    if (reset) begin
      state          <= ST_ARB;
      rr_ptr         <= 2'd2;
      owner          <= 2'd0;
      tmo_cnt        <= '0;
      hold_cnt       <= '0;
      link_tp        <= 1'b0;
      link_tp_fields <= '0;
      grant          <= 3'b000;
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      ack_c          <= 1'b0;
      err_timeout    <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      ack_c <= 1'b0;
      case (state)
        ST_ARB: begin
          if (link_tp_ack) err_spurious <= 1'b1;
          if (win_valid) begin
            link_tp <= 1'b1;
            owner   <= win_idx;
            grant   <= 3'b001 << win_idx;
            tmo_cnt <= '0;
            state   <= ST_SEND;
            case (win_idx)
              2'd0:    link_tp_fields <= req_a_tp;
              2'd1:    link_tp_fields <= req_b_tp;
              default: link_tp_fields <= req_c_tp;
            endcase
          end
        end
        ST_SEND: begin
          if (link_tp_ack) begin
            link_tp  <= 1'b0;
            grant    <= 3'b000;
            rr_ptr   <= owner;
            hold_cnt <= HOLD_INIT;
            state    <= ST_HOLD;
            case (owner)
              2'd0:    ack_a <= 1'b1;
              2'd1:    ack_b <= 1'b1;
              default: ack_c <= 1'b1;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            link_tp     <= 1'b0;
            grant       <= 3'b000;
            err_timeout <= 1'b1;
            hold_cnt    <= HOLD_INIT;
            state       <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 11'd1;
          end
        end
        ST_HOLD: begin
          if (link_tp_ack) err_spurious <= 1'b1;
          if (hold_cnt == 11'd0) state <= ST_ARB;
          else hold_cnt <= hold_cnt - 11'd1;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_tp_arbiter.sv
// tb_usb3_tp_arbiter: three arbiter instances (fixed priority, round-robin,
// fixed priority with short timeout and two-cycle hold-off) driven by
// per-instance requester and link responders, compared every cycle against a
// transaction-level model, plus literal expectations for the directed scenarios.
module tb_usb3_tp_arbiter;

  logic        local_clk = 1'b0;
  logic        reset;
  logic [2:0]  d_req     [3];
  logic [35:0] req_tp    [3];
  logic        d_lack    [3];
  logic        d_link_tp [3];
  logic [35:0] d_fields  [3];
  logic [2:0]  d_grant   [3];
  logic [2:0]  d_ack     [3];
  logic        d_et      [3];
  logic        d_es      [3];

  int checks = 0;
  int errors = 0;

  // Stimulus state: per-instance pending requests, link ack latency, log of acked winners.
  bit pend    [3][3];
  bit persist [3];
  int lat     [3];
  int hi_cnt  [3];
  int glog    [3][16];
  int gcnt    [3];
  bit force_ack;

  // Model configuration and state.
  int          m_rr   [3] = '{0, 1, 0};
  int          m_hold [3] = '{1, 1, 2};
  int          m_tmo  [3] = '{1023, 1023, 8};
  int          ph  [3];
  int          own [3];
  int          el  [3];
  int          hl  [3];
  int          last[3];
  bit          e_link   [3];
  logic [35:0] e_fields [3];
  logic [2:0]  e_grant  [3];
  logic [2:0]  e_ack    [3];
  bit          e_et     [3];
  bit          e_es     [3];
  bit          m_valid = 1'b0;

  always #5 local_clk = ~local_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    usb3_tp_arbiter #(
      .RR      (g == 1),
      .HOLDOFF ((g == 2) ? 2 : 1),
      .TIMEOUT ((g == 2) ? 8 : 1023)
    ) dut (
      .local_clk      (local_clk),
      .reset          (reset),
      .req_a          (d_req[g][0]),
      .req_b          (d_req[g][1]),
      .req_c          (d_req[g][2]),
      .req_a_tp       (req_tp[0]),
      .req_b_tp       (req_tp[1]),
      .req_c_tp       (req_tp[2]),
      .ack_a          (d_ack[g][0]),
      .ack_b          (d_ack[g][1]),
      .ack_c          (d_ack[g][2]),
      .link_tp        (d_link_tp[g]),
      .link_tp_fields (d_fields[g]),
      .link_tp_ack    (d_lack[g]),
      .grant          (d_grant[g]),
      .err_timeout    (d_et[g]),
      .err_spurious   (d_es[g])
    );
  end

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One model step per clock: one TP at a time, winner chosen by scanning the
  // requesters in priority order, fixed-length send window and hold window.
  task automatic model_step(input int d);
    int r;
    e_ack[d] = 3'b000;
    if (reset) begin
      ph[d] = 0; el[d] = 0; hl[d] = 0; own[d] = 0; last[d] = 2;
      e_link[d] = 1'b0; e_fields[d] = '0; e_grant[d] = 3'b000;
      e_et[d] = 1'b0; e_es[d] = 1'b0;
    end else begin
      case (ph[d])
        0: begin
          if (d_lack[d]) e_es[d] = 1'b1;
          r = -1;
          for (int k = 3; k >= 1; k--) begin
            int c;
            c = (m_rr[d] != 0) ? (last[d] + k) % 3 : k - 1;
            if (d_req[d][c]) r = c;
          end
          if (r >= 0) begin
            ph[d] = 1; own[d] = r; el[d] = 0;
            e_link[d] = 1'b1; e_fields[d] = req_tp[r]; e_grant[d] = 3'(1 << r);
          end
        end
        1: begin
          el[d]++;
          if (d_lack[d]) begin
            e_ack[d][own[d]] = 1'b1;
            last[d] = own[d];
            e_link[d] = 1'b0; e_grant[d] = 3'b000; ph[d] = 2; hl[d] = m_hold[d];
          end else if (el[d] == m_tmo[d]) begin
            e_et[d] = 1'b1;
            e_link[d] = 1'b0; e_grant[d] = 3'b000; ph[d] = 2; hl[d] = m_hold[d];
          end
        end
        default: begin
          if (d_lack[d]) e_es[d] = 1'b1;
          hl[d]--;
          if (hl[d] == 0) ph[d] = 0;
        end
      endcase
    end
  endtask

  // Advance the model on every active edge with the inputs the DUTs sampled.
  always @(posedge local_clk) begin
    for (int d = 0; d < 3; d++) model_step(d);
    m_valid = 1'b1;
  end

  task automatic check_output(input int d);
    cmp($sformatf("dut%0d link_tp", d),      36'(d_link_tp[d]), 36'(e_link[d]));
    cmp($sformatf("dut%0d fields", d),       d_fields[d],       e_fields[d]);
    cmp($sformatf("dut%0d grant", d),        36'(d_grant[d]),   36'(e_grant[d]));
    cmp($sformatf("dut%0d ack", d),          36'(d_ack[d]),     36'(e_ack[d]));
    cmp($sformatf("dut%0d err_timeout", d),  36'(d_et[d]),      36'(e_et[d]));
    cmp($sformatf("dut%0d err_spurious", d), 36'(d_es[d]),      36'(e_es[d]));
  endtask

  // Compare every instance against the model mid-cycle.
  always @(negedge local_clk) begin
    if (m_valid) for (int d = 0; d < 3; d++) check_output(d);
  end

  // Registered requesters keep req high in the cycle their ack is seen; the
  // link responder acks once link_tp has been high for lat cycles.
  task automatic apply_stimulus();
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 3; r++) begin
        if (d_ack[d][r] === 1'b1) begin
          if (!persist[r]) pend[d][r] = 1'b0;
          if (gcnt[d] < 16) glog[d][gcnt[d]] = r;
          gcnt[d]++;
        end
        d_req[d][r] = pend[d][r] | (d_ack[d][r] === 1'b1);
      end
      hi_cnt[d] = (d_link_tp[d] === 1'b1) ? hi_cnt[d] + 1 : 0;
      d_lack[d] = force_ack | (lat[d] != 0 && d_link_tp[d] === 1'b1 && hi_cnt[d] == lat[d]);
    end
  endtask

  task automatic step();
    @(posedge local_clk);
    #1;
    apply_stimulus();
  endtask

  task automatic clear_pend();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 3; r++) pend[d][r] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_pend();
    step();
    reset = 1'b0;
    step();
    for (int d = 0; d < 3; d++) gcnt[d] = 0;
  endtask

  task automatic wait_rise(input int d, input int budget);
    for (int i = 0; i < budget && d_link_tp[d] !== 1'b1; i++) step();
  endtask

  initial begin
    reset     = 1'b1;
    force_ack = 1'b0;
    for (int d = 0; d < 3; d++) begin
      d_req[d] = 3'b000; d_lack[d] = 1'b0; lat[d] = 0; hi_cnt[d] = 0; gcnt[d] = 0;
      persist[d] = 1'b0; req_tp[d] = '0;
    end
    clear_pend();
    step();
    step();
    reset = 1'b0;
    cmp("reset link_tp", 36'(d_link_tp[0]), 36'd0);
    cmp("reset grant",   36'(d_grant[0]),   36'd0);
    cmp("reset errors",  36'({d_et[0], d_es[0]}), 36'd0);

    // Single ACK-to-DPH TP from A, link acks on its third cycle.
    for (int d = 0; d < 3; d++) lat[d] = 3;
    req_tp[0] = {1'b0, 1'b0, 4'h1, 4'd2, 5'd1, 5'd5, 16'h0000};
    for (int d = 0; d < 3; d++) pend[d][0] = 1'b1;
    step();
    step();
    cmp("t1 link_tp N+1", 36'(d_link_tp[0]), 36'd1);
    cmp("t1 fields N+1",  d_fields[0],       36'h0_4825_0000);
    cmp("t1 grant N+1",   36'(d_grant[0]),   36'b001);
    step();
    cmp("t1 link_tp N+2", 36'(d_link_tp[0]), 36'd1);
    step();
    cmp("t1 link_tp N+3", 36'(d_link_tp[0]), 36'd1);
    cmp("t1 ack_a N+3",   36'(d_ack[0]),     36'b000);
    step();
    cmp("t1 ack_a N+4",   36'(d_ack[0]),     36'b001);
    cmp("t1 link_tp N+4", 36'(d_link_tp[0]), 36'd0);
    step();
    cmp("t1 ack_a N+5",   36'(d_ack[0]),     36'b000);

    // All three request once each; each holds req one cycle past its ack.
    do_reset();
    req_tp[1] = 36'h1_2345_6789;
    req_tp[2] = 36'h2_0F0F_A5A5;
    for (int d = 0; d < 3; d++) for (int r = 0; r < 3; r++) pend[d][r] = 1'b1;
    for (int i = 0; i < 60 && !(gcnt[0] >= 3 && gcnt[1] >= 3 && gcnt[2] >= 3); i++) step();
    for (int i = 0; i < 10; i++) step();
    for (int d = 0; d < 3; d++) begin
      cmp($sformatf("t2 dut%0d grant count", d), 36'(gcnt[d]), 36'd3);
      for (int k = 0; k < 3; k++)
        cmp($sformatf("t2 dut%0d order %0d", d, k), 36'(glog[d][k]), 36'(k));
    end

    // A re-requests immediately after every ack; B and C wait.
    do_reset();
    persist[0] = 1'b1;
    for (int d = 0; d < 3; d++) for (int r = 0; r < 3; r++) pend[d][r] = 1'b1;
    for (int i = 0; i < 80 && !(gcnt[0] >= 4 && gcnt[1] >= 4); i++) step();
    cmp("t2b dut0 order", 36'({glog[0][0][1:0], glog[0][1][1:0], glog[0][2][1:0], glog[0][3][1:0]}), 36'b00_00_00_00);
    cmp("t2b dut1 order", 36'({glog[1][0][1:0], glog[1][1][1:0], glog[1][2][1:0], glog[1][3][1:0]}), 36'b00_01_10_00);
    persist[0] = 1'b0;
    clear_pend();
    for (int i = 0; i < 12; i++) step();

    // B with a silent link on the short-timeout instance.
    do_reset();
    lat[2] = 0;
    for (int d = 0; d < 3; d++) pend[d][1] = 1'b1;
    wait_rise(2, 5);
    begin
      int n;
      n = 0;
      while (d_link_tp[2] === 1'b1 && n < 20) begin
        n++;
        step();
      end
      cmp("t4 link_tp high cycles", 36'(n), 36'd8);
    end
    cmp("t4 err_timeout set", 36'(d_et[2]), 36'd1);
    cmp("t4 no ack_b",        36'(gcnt[2]), 36'd0);
    wait_rise(2, 10);
    cmp("t4 regrant link_tp", 36'(d_link_tp[2]), 36'd1);
    cmp("t4 regrant grant",   36'(d_grant[2]),   36'b010);
    lat[2] = 3;
    for (int i = 0; i < 10 && gcnt[2] < 1; i++) step();
    cmp("t4 late ack count",  36'(gcnt[2]),    36'd1);
    cmp("t4 late ack winner", 36'(glog[2][0]), 36'd1);
    cmp("t4 err_timeout sticky", 36'(d_et[2]), 36'd1);
    for (int i = 0; i < 6; i++) step();

    // Reset in the middle of a send.
    for (int d = 0; d < 3; d++) pend[d][0] = 1'b1;
    wait_rise(0, 10);
    cmp("t5 in SEND", 36'(d_link_tp[0]), 36'd1);
    reset = 1'b1;
    clear_pend();
    step();
    reset = 1'b0;
    cmp("t5 link_tp", 36'(d_link_tp[0]), 36'd0);
    cmp("t5 grant",   36'(d_grant[0]),   36'd0);
    cmp("t5 acks",    36'(d_ack[0]),     36'd0);
    cmp("t5 err_timeout cleared", 36'(d_et[2]), 36'd0);
    step();
    for (int d = 0; d < 3; d++) gcnt[d] = 0;

    // Link ack with nothing pending, then C drops its request mid-send.
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    cmp("t6 err_spurious", 36'(d_es[0]), 36'd1);
    cmp("t6 no ack",       36'(d_ack[0]), 36'd0);
    for (int d = 0; d < 3; d++) lat[d] = 6;
    req_tp[2] = {1'b1, 1'b1, 4'h2, 4'd3, 5'd2, 5'd9, 16'hBEEF};
    for (int d = 0; d < 3; d++) pend[d][2] = 1'b1;
    wait_rise(0, 6);
    cmp("t6 fields latched", d_fields[0], 36'hC_8C49_BEEF);
    clear_pend();
    req_tp[2] = 36'h0_0000_1111;
    step();
    step();
    cmp("t6 fields held", d_fields[0], 36'hC_8C49_BEEF);
    for (int i = 0; i < 20 && gcnt[0] < 1; i++) step();
    cmp("t6 ack_c count",  36'(gcnt[0]),    36'd1);
    cmp("t6 ack_c winner", 36'(glog[0][0]), 36'd2);
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
